// File: rtl/srl_bus_sched.sv
// srl_bus_sched: round-robin scheduler that feeds one fixed-latency delay line
// shared by N_REQ requesters. Each word accepted into the line carries its
// requester index, and the word leaves the line CLK_CYCL enabled cycles later.
// Optional feature macro: SRL_SCHED_CNT_EN adds the saturating per-requester
// acc_cnt counters.
module srl_bus_sched #(
    parameter int N_REQ    = 4,
    parameter int WIDTH    = 8,
    parameter int CLK_CYCL = 4,
    localparam int ID_W    = $clog2(N_REQ)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en,
    input  logic [N_REQ-1:0]             req_valid,
    input  logic [N_REQ-1:0][WIDTH-1:0]  req_data,
    output logic [N_REQ-1:0]             req_ready,
    output logic                         out_valid,
    output logic [ID_W-1:0]              out_id,
    output logic [WIDTH-1:0]             out_data
`ifdef SRL_SCHED_CNT_EN
    ,
    output logic [N_REQ-1:0][15:0]       acc_cnt
`else
`endif
);

    logic [ID_W-1:0]  r_ptr;
    logic             r_vld  [CLK_CYCL];
    logic [ID_W-1:0]  r_id   [CLK_CYCL];
    logic [WIDTH-1:0] r_data [CLK_CYCL];

    logic [N_REQ-1:0] w_grant;
    logic [ID_W-1:0]  w_gIdx;
    logic [ID_W-1:0]  w_cand;
    logic             w_found;
    int               w_idx;

    // Round-robin search from the pointer, wrapping around; the first valid
    // requester wins. Held in reset and while disabled, nobody is granted.
    always_comb begin
        w_grant = '0;
        w_gIdx  = '0;
        w_cand  = '0;
        w_found = 1'b0;
        w_idx   = 0;
        if (rst && en) begin
            for (int k = 0; k < N_REQ; k++) begin
                w_idx = int'(r_ptr) + k;
                if (w_idx >= N_REQ) begin
                    w_idx = w_idx - N_REQ;
                end
                w_cand = ID_W'(w_idx);
                if (!w_found && req_valid[w_cand]) begin
                    w_found = 1'b1;
                    w_gIdx  = w_cand;
                end
            end
        end
        if (w_found) begin
            w_grant[w_gIdx] = 1'b1;
        end
    end

    assign req_ready = w_grant;

    // Priority pointer moves just past the requester that was served.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ptr <= '0;
        end else if (en && w_found) begin
            r_ptr <= (w_gIdx == ID_W'(N_REQ - 1)) ? '0 : w_gIdx + 1'b1;
        end
    end

    // Delay line: stage 0 captures the granted word (or a zero bubble), the
    // rest shift along; everything freezes while en is low.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < CLK_CYCL; k++) begin
                r_vld[k]  <= 1'b0;
                r_id[k]   <= '0;
                r_data[k] <= '0;
            end
        end else if (en) begin
            r_vld[0]  <= w_found;
            r_id[0]   <= w_found ? w_gIdx : '0;
            r_data[0] <= w_found ? req_data[w_gIdx] : '0;
            for (int k = 1; k < CLK_CYCL; k++) begin
                r_vld[k]  <= r_vld[k-1];
                r_id[k]   <= r_id[k-1];
                r_data[k] <= r_data[k-1];
            end
        end
    end

    assign out_valid = r_vld[CLK_CYCL-1];
    assign out_id    = r_id[CLK_CYCL-1];
    assign out_data  = r_data[CLK_CYCL-1];

`ifdef SRL_SCHED_CNT_EN
    logic [N_REQ-1:0][15:0] r_accCnt;

    // Per-requester accepted-word counters, saturating at all ones.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_accCnt <= '0;
        end else if (en) begin
            for (int i = 0; i < N_REQ; i++) begin
                if (w_grant[i] && (r_accCnt[i] != 16'hFFFF)) begin
                    r_accCnt[i] <= r_accCnt[i] + 16'd1;
                end
            end
        end
    end

    assign acc_cnt = r_accCnt;
`else
    // Default build carries no counter state.
`endif

endmodule
